// File: rtl/ddr_resp_pkg.sv
// Shared widths, FSM state type and burstcount helpers for the DDR EMIF burst responder.
package ddr_resp_pkg;

  localparam int unsigned DATA_W    = 512;
  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned BURST_MAX = 64;
  localparam int unsigned LEN_W     = $clog2(BURST_MAX) + 1;

  typedef enum logic [1:0] {IDLE, WR, RD} state_e;

  typedef logic [LEN_W-1:0] len_t;

  function automatic logic burst_legal(input int unsigned bc);
    return (bc != 0) && (bc <= BURST_MAX);
  endfunction

  // Out-of-range burstcounts collapse to a single beat.
  function automatic len_t sanitise_burst(input int unsigned bc);
    return burst_legal(bc) ? len_t'(bc) : len_t'(1);
  endfunction

endpackage

// File: rtl/ddr_resp_ram.sv
// Single-port byte-enabled RAM with a one-cycle registered read port.
module ddr_resp_ram
  import ddr_resp_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  localparam int unsigned AW   = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     addr,
  input  logic              we,
  input  logic              re,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Output register resets so readdata is defined out of reset and holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ddr_emif_burst_responder.sv
// Avalon-MM burst slave that backs one EMIF DDR4 port with on-chip RAM.
// Defining DDR_RESP_STATS_EN adds stat_rd_beats / stat_wr_beats beat counters.
module ddr_emif_burst_responder
  import ddr_resp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BURST_W   = 7,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  output logic               s_waitrequest,
  output logic [DATA_W-1:0]  s_readdata,
  output logic               s_readdatavalid,
  input  logic [BURST_W-1:0] s_burstcount,
  input  logic [DATA_W-1:0]  s_writedata,
  input  logic [ADDR_W-1:0]  s_address,
  input  logic               s_write,
  input  logic               s_read,
  input  logic [BE_W-1:0]    s_byteenable,
  input  logic               s_debugaccess,
  output logic               err_sticky
`ifdef DDR_RESP_STATS_EN
  ,
  output logic [31:0]        stat_rd_beats,
  output logic [31:0]        stat_wr_beats
`endif
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  state_e           state_q;
  logic [IDX_W-1:0] base_q;
  len_t             len_q;
  len_t             cnt_q;
  logic             wait_q;
  logic             rvalid_q;
  logic             err_q;

  logic [IDX_W-1:0] cmd_idx;
  len_t             cmd_len;
  logic             cmd_bad;
  logic             idle_ready;
  logic             last_beat;
  logic             ram_we;
  logic             ram_re;
  logic [IDX_W-1:0] ram_addr;

  logic unused_inputs;
  assign unused_inputs = ^{s_debugaccess, s_address[5:0], s_address[ADDR_W-1:6+IDX_W]};

  assign cmd_idx    = s_address[6 +: IDX_W];
  assign cmd_len    = sanitise_burst(32'(s_burstcount));
  assign cmd_bad    = !burst_legal(32'(s_burstcount));
  // wait_q is still high for the first clock after reset, which blocks acceptance there.
  assign idle_ready = (state_q == IDLE) && !wait_q;
  assign last_beat  = (cnt_q == len_q - LEN_W'(1));

  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = base_q + IDX_W'(cnt_q);
    unique case (state_q)
      IDLE: begin
        if (idle_ready && s_write) begin
          ram_we   = 1'b1;
          ram_addr = cmd_idx;
        end
      end
      WR:      ram_we = s_write;
      RD:      ram_re = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= LEN_W'(1);
      cnt_q    <= '0;
      wait_q   <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wait_q   <= 1'b0;
      rvalid_q <= ram_re;
      unique case (state_q)
        IDLE: begin
          if (idle_ready && (s_write || s_read)) begin
            base_q <= cmd_idx;
            len_q  <= cmd_len;
            if (cmd_bad || (s_write && s_read)) err_q <= 1'b1;
            if (s_write) begin
              // Beat 0 is committed in the accept cycle; a colliding read is dropped.
              cnt_q <= LEN_W'(1);
              if (cmd_len > LEN_W'(1)) state_q <= WR;
            end else begin
              cnt_q   <= '0;
              state_q <= RD;
              wait_q  <= 1'b1;
            end
          end
        end
        WR: begin
          if (s_read) err_q <= 1'b1;
          if (s_write) begin
            if (last_beat) state_q <= IDLE;
            else           cnt_q   <= cnt_q + LEN_W'(1);
          end
        end
        RD: begin
          if (last_beat) begin
            state_q <= IDLE;
          end else begin
            cnt_q  <= cnt_q + LEN_W'(1);
            wait_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ddr_resp_ram #(
    .WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .addr  (ram_addr),
    .we    (ram_we),
    .re    (ram_re),
    .be    (s_byteenable),
    .wdata (s_writedata),
    .rdata (s_readdata)
  );

  assign s_waitrequest   = wait_q;
  assign s_readdatavalid = rvalid_q;
  assign err_sticky      = err_q;

`ifdef DDR_RESP_STATS_EN
  logic [31:0] stat_rd_q;
  logic [31:0] stat_wr_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      if (rvalid_q) stat_rd_q <= stat_rd_q + 32'd1;
      if (ram_we)   stat_wr_q <= stat_wr_q + 32'd1;
    end
  end

  assign stat_rd_beats = stat_rd_q;
  assign stat_wr_beats = stat_wr_q;
`endif

endmodule
